shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's shift-register serializer. Accepts a stream of FROM-bit beats and reassembles them into TO-bit words, R = TO/FROM beats per word.
- Beat order is MSB-chunk first, matching the serializer's output order: the first beat ends up in data_o[TO-1 -: FROM] and the last beat in data_o[FROM-1:0].
- Sits at the end of a narrow serial link. Presents complete words to a wide consumer through a valid/ready handshake, with one output holding register so collection of the next word overlaps draining of the current one.

Parameters:
FROM, 1, input beat width in bits; TO mod FROM == 0.
TO, 8, output word width in bits; R = TO/FROM >= 2.
LOG2BEATS, 3, beat counter width; must satisfy 2**LOG2BEATS >= R.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  reset, asynchronous, active-high.
data_i  input  FROM  incoming beat.
valid_i  input  1  beat valid.
ready_o  output  1  deserializer can accept a beat this cycle.
clear_i  input  1  synchronous discard of the partially assembled word.
data_o  output  TO  assembled word; stable while valid_o is high.
valid_o  output  1  data_o holds a complete word.
ready_i  input  1  consumer accepts the word.

Behaviour:
- Reset (async, any cycle including mid-word): ready_o=1, valid_o=0, data_o=0, shift register=0, beat counter=0, state=IDLE. Partial and held words are lost.
- Beat accepted when valid_i & ready_o. On accept: shift <= {shift[TO-FROM-1:0], data_i}, cnt <= cnt+1.
- Words only: no output on partial words. Counter wraps to 0 on the R-th accepted beat.
- Output register:
  - Loaded with {shift[TO-FROM-1:0], data_i} on the R-th accepted beat (cycle t).
  - valid_o=1 from cycle t+1; latency is 1 cycle from last beat to valid_o.
  - Word drained when valid_o & ready_i; valid_o falls the next cycle unless a new word loads in that same cycle.
  - data_o holds its value while valid_o=1 & ready_i=0.
  - After draining, data_o keeps its last value; it is not cleared.
- State machine (input side):
  - IDLE: cnt=0, ready_o=1. Accepted beat -> COLLECT.
  - COLLECT: 0<cnt<=R-1, ready_o=1 except at cnt==R-1 with valid_o=1 (out_full).
    - At cnt==R-1, accepted beat -> IDLE, word loads into output register.
    - At cnt==R-1 with out_full -> STALL.
  - STALL: cnt==R-1, ready_o=0, no beat accepted. When valid_o & ready_i -> COLLECT; ready_o=1 the next cycle.
- ready_o is a function of registered state only. No combinational path from ready_i or valid_i to ready_o.
- Simultaneous last beat and output drain: cannot occur in STALL. In COLLECT at cnt==R-1 with valid_o=0, the load happens normally.
- Full throughput: with ready_i held 1 and valid_i held 1, one beat is accepted every cycle, no bubbles, and one word is produced every R cycles.
- clear_i has priority over a beat accept in the same cycle:
  - cnt <= 0, shift <= 0, state <= IDLE; the beat presented that cycle is dropped.
  - The output register and valid_o are unaffected.
- valid_i=0 in any state: no shift, counter holds, no timeout.

Test Plan:
- FROM=1,TO=8, ready_i=1. Beats 1,0,1,1,0,0,1,0 on consecutive cycles -> valid_o=1 exactly one cycle after the 8th beat, data_o=8'hB2; ready_o never falls.
- FROM=2,TO=8. Beats 2'b11,2'b00,2'b01,2'b10 -> data_o=8'hC6; back-to-back second word 2'b01,2'b01,2'b01,2'b01 -> data_o=8'h55 four cycles later, no gaps.
- FROM=1,TO=8, ready_i=0. Send word 8'hA5, then 7 beats of 8'h3C -> ready_o=0 at the 8th beat, data_o holds 8'hA5.
  - Then raise ready_i for 1 cycle -> 8'hA5 drained, ready_o=1 the next cycle.
  - Final beat then yields data_o=8'h3C.
- Assert reset after 5 beats of a word and while valid_o=1 -> valid_o=0, data_o=0, ready_o=1 immediately.
  - A following full word 8'hF0 is assembled correctly.
- clear_i after 3 beats, coincident with a valid beat -> that beat dropped.
  - The next 8 beats of 8'h81 produce data_o=8'h81.
  - A previously held, undrained word stays valid until drained.
- Randomized valid_i gaps over 100 words, FROM=4,TO=16 -> every word matches the scoreboard and MSB-chunk-first order is preserved.

Source files
------------

// File: rtl/shift_deserializer.sv
// shift_deserializer
//   Reassembles a stream of FROM-bit beats into TO-bit words, MSB chunk
//   first (the first beat lands in data_o[TO-1 -: FROM]). One output
//   holding register lets the next word be collected while the current
//   one waits for the consumer.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. The producer holds data while valid is high and ready
//   is low. ready_o depends only on registered state.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   data_i   in   [FROM-1:0] incoming beat
//   valid_i  in   beat valid
//   ready_o  out  beat can be accepted this cycle
//   clear_i  in   synchronous discard of the partially assembled word
//   data_o   out  [TO-1:0] assembled word, stable while valid_o is high
//   valid_o  out  data_o holds a complete word
//   ready_i  in   consumer accepts the word
module shift_deserializer #(
    parameter int FROM      = 1,
    parameter int TO        = 8,
    parameter int LOG2BEATS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FROM-1:0] data_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            clear_i,
    output logic [TO-1:0]   data_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam int R = TO / FROM;
    localparam logic [LOG2BEATS-1:0] LAST_CNT = LOG2BEATS'(R - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LOG2BEATS-1:0] cnt_q, cnt_d;
    logic [TO-1:0]        shift_q, shift_d;
    logic [TO-1:0]        out_q, out_d;
    logic                 valid_q, valid_d;

    logic at_last;
    logic beat_acc;
    logic drain;
    logic load;
    logic [TO-1:0] shift_next;

    always_comb begin
        at_last    = (cnt_q == LAST_CNT);
        // The last beat can only be taken once the holding register is
        // empty; both terms are flops, so ready_o has no input path.
        ready_o    = !(at_last && valid_q);
        beat_acc   = valid_i && ready_o && !clear_i;
        drain      = valid_q && ready_i;
        load       = beat_acc && at_last;
        shift_next = {shift_q[TO-FROM-1:0], data_i};

        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = valid_q;

        // Input side: clear wins over a beat presented in the same cycle.
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = IDLE;
        end else if (beat_acc) begin
            shift_d = shift_next;
            if (at_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + LOG2BEATS'(1);
                state_d = COLLECT;
            end
        end else begin
            case (state_q)
                COLLECT: if (at_last && valid_q && !drain) state_d = STALL;
                STALL:   if (drain) state_d = COLLECT;
                default: state_d = state_q;
            endcase
        end

        // Output side: a load never coincides with a held word because
        // the last beat is refused while valid_q is set.
        if (load) begin
            out_d   = shift_next;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = out_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer
//   Directed tests for three configurations of shift_deserializer:
//   FROM=1/TO=8, FROM=2/TO=8 and FROM=4/TO=16. Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
module tb_shift_deserializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // FROM=1, TO=8
    logic       d1 = '0, v1 = 1'b0, clr1 = 1'b0, ri1 = 1'b0;
    logic       rdy1, vo1;
    logic [7:0] q1;
    // FROM=2, TO=8
    logic [1:0] d2 = '0;
    logic       v2 = 1'b0, clr2 = 1'b0, ri2 = 1'b0;
    logic       rdy2, vo2;
    logic [7:0] q2;
    // FROM=4, TO=16
    logic [3:0]  d4 = '0;
    logic        v4 = 1'b0, clr4 = 1'b0, ri4 = 1'b0;
    logic        rdy4, vo4;
    logic [15:0] q4;

    logic [15:0] exp_q[$];

    shift_deserializer #(.FROM(1), .TO(8), .LOG2BEATS(3)) u_dut1 (
        .clk(clk), .reset(reset), .data_i(d1), .valid_i(v1), .ready_o(rdy1),
        .clear_i(clr1), .data_o(q1), .valid_o(vo1), .ready_i(ri1));

    shift_deserializer #(.FROM(2), .TO(8), .LOG2BEATS(3)) u_dut2 (
        .clk(clk), .reset(reset), .data_i(d2), .valid_i(v2), .ready_o(rdy2),
        .clear_i(clr2), .data_o(q2), .valid_o(vo2), .ready_i(ri2));

    shift_deserializer #(.FROM(4), .TO(16), .LOG2BEATS(3)) u_dut4 (
        .clk(clk), .reset(reset), .data_i(d4), .valid_i(v4), .ready_o(rdy4),
        .clear_i(clr4), .data_o(q4), .valid_o(vo4), .ready_i(ri4));

    // Presents the first n bits of w to DUT1, MSB first, one per cycle,
    // expecting ready_o high for each. Leaves the last beat presented.
    task automatic send1(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_checks++;
            if (rdy1 !== 1'b1) $display("FAIL send1_ready beat %0d: got %b expected 1", i, rdy1);
            else n_pass++;
            d1 = w[7-i];
            v1 = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rdy1, vo1, q1} !== {1'b1, 1'b0, 8'h00}) $display("FAIL reset_dut1: got rdy=%b vld=%b data=%h expected 1 0 00", rdy1, vo1, q1);
        else n_pass++;
        n_checks++;
        if ({rdy2, vo2, q2} !== {1'b1, 1'b0, 8'h00}) $display("FAIL reset_dut2: got rdy=%b vld=%b data=%h expected 1 0 00", rdy2, vo2, q2);
        else n_pass++;
        n_checks++;
        if ({rdy4, vo4, q4} !== {1'b1, 1'b0, 16'h0000}) $display("FAIL reset_dut4: got rdy=%b vld=%b data=%h expected 1 0 0000", rdy4, vo4, q4);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_full_rate();
        ri1 = 1'b1;
        send1(8'hB2, 8);
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'hB2}) $display("FAIL full_rate_word: got vld=%b data=%h expected 1 b2", vo1, q1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (vo1 !== 1'b0) $display("FAIL full_rate_drained: got vld=%b expected 0", vo1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] beats[8] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        ri2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (rdy2 !== 1'b1) $display("FAIL b2b_ready beat %0d: got %b expected 1", i, rdy2);
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if ({vo2, q2} !== {1'b1, 8'hC6}) $display("FAIL b2b_word0: got vld=%b data=%h expected 1 c6", vo2, q2);
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if (vo2 !== 1'b0) $display("FAIL b2b_gap: got vld=%b expected 0", vo2);
                else n_pass++;
            end
            d2 = beats[i];
            v2 = 1'b1;
        end
        @(negedge clk);
        v2 = 1'b0;
        n_checks++;
        if ({vo2, q2} !== {1'b1, 8'h55}) $display("FAIL b2b_word1: got vld=%b data=%h expected 1 55", vo2, q2);
        else n_pass++;
        @(negedge clk);
        ri2 = 1'b0;
    endtask

    task automatic test_stall();
        ri1 = 1'b0;
        send1(8'hA5, 8);
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'hA5}) $display("FAIL stall_held: got vld=%b data=%h expected 1 a5", vo1, q1);
        else n_pass++;
        send1(8'h3C, 7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d1 = 1'b0;
            v1 = 1'b1;
            n_checks++;
            if ({rdy1, vo1, q1} !== {1'b0, 1'b1, 8'hA5}) $display("FAIL stall_blocked cyc %0d: got rdy=%b vld=%b data=%h expected 0 1 a5", i, rdy1, vo1, q1);
            else n_pass++;
        end
        ri1 = 1'b1;
        @(negedge clk);
        ri1 = 1'b0;
        n_checks++;
        if ({rdy1, vo1, q1} !== {1'b1, 1'b0, 8'hA5}) $display("FAIL stall_release: got rdy=%b vld=%b data=%h expected 1 0 a5", rdy1, vo1, q1);
        else n_pass++;
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'h3C}) $display("FAIL stall_final_word: got vld=%b data=%h expected 1 3c", vo1, q1);
        else n_pass++;
        ri1 = 1'b1;
        @(negedge clk);
        ri1 = 1'b0;
        n_checks++;
        if (vo1 !== 1'b0) $display("FAIL stall_final_drain: got vld=%b expected 0", vo1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        ri1 = 1'b0;
        send1(8'h96, 8);
        send1(8'h6B, 5);
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'h96}) $display("FAIL rst_mid_pre: got vld=%b data=%h expected 1 96", vo1, q1);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({rdy1, vo1, q1} !== {1'b1, 1'b0, 8'h00}) $display("FAIL rst_mid_async: got rdy=%b vld=%b data=%h expected 1 0 00", rdy1, vo1, q1);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        ri1 = 1'b1;
        send1(8'hF0, 8);
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'hF0}) $display("FAIL rst_mid_next_word: got vld=%b data=%h expected 1 f0", vo1, q1);
        else n_pass++;
        @(negedge clk);
        ri1 = 1'b0;
    endtask

    task automatic test_clear();
        ri1 = 1'b0;
        send1(8'h5A, 8);
        send1(8'hE0, 3);
        @(negedge clk);
        clr1 = 1'b1;
        d1   = 1'b0;
        v1   = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        v1   = 1'b0;
        n_checks++;
        if ({rdy1, vo1, q1} !== {1'b1, 1'b1, 8'h5A}) $display("FAIL clear_keeps_held: got rdy=%b vld=%b data=%h expected 1 1 5a", rdy1, vo1, q1);
        else n_pass++;
        ri1 = 1'b1;
        @(negedge clk);
        ri1 = 1'b0;
        n_checks++;
        if (vo1 !== 1'b0) $display("FAIL clear_held_drain: got vld=%b expected 0", vo1);
        else n_pass++;
        ri1 = 1'b1;
        send1(8'h81, 8);
        @(negedge clk);
        v1 = 1'b0;
        n_checks++;
        if ({vo1, q1} !== {1'b1, 8'h81}) $display("FAIL clear_next_word: got vld=%b data=%h expected 1 81", vo1, q1);
        else n_pass++;
        @(negedge clk);
        ri1 = 1'b0;
    endtask

    task automatic test_random_gaps();
        logic [15:0] words[100];
        logic [15:0] exp_w;
        int widx = 0, bidx = 0, drained = 0, cycles = 0;
        for (int i = 0; i < 100; i++) begin
            words[i] = 16'($urandom_range(0, 65535));
            exp_q.push_back(words[i]);
        end
        while (drained < 100 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            ri4 = ($urandom_range(0, 3) != 0);
            if (vo4 && ri4) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_word: got %h expected none", q4);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (q4 !== exp_w) $display("FAIL rand_word %0d: got %h expected %h", drained, q4, exp_w);
                    else n_pass++;
                end
                drained++;
            end
            if (widx < 100 && $urandom_range(0, 3) != 0) begin
                v4 = 1'b1;
                d4 = words[widx][15-4*bidx -: 4];
                if (rdy4) begin
                    bidx++;
                    if (bidx == 4) begin
                        bidx = 0;
                        widx++;
                    end
                end
            end else begin
                v4 = 1'b0;
            end
        end
        v4  = 1'b0;
        ri4 = 1'b0;
        n_checks++;
        if (drained != 100) $display("FAIL rand_word_count: got %0d expected 100", drained);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_clear();
        test_random_gaps();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
